dice_roller: RTL and testbench
==============================

DICE_ROLLER -- requirements
Module: dice_roller

Interface
REQ-001 Parameter DB_LIMIT, default 16'd50_000: consecutive stable synchronised-button cycles required to accept a new debounced level.
REQ-002 Parameter TICK_DIV, default 24'd2_500_000: clk cycles per animation tick (20 Hz at 50 MHz).
REQ-003 Parameter ROLL_TICKS, default 8'd20: animation ticks per roll (minimum 1).
REQ-004 Port clk, input, 1: the single clock for the block.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port ena, input, 1: design enable; low forces idle.
REQ-007 Port rand_byte, input, 8: random byte from the upstream LFSR/mux stage.
REQ-008 Port rand_valid, input, 1: one-cycle strobe marking rand_byte as new.
REQ-009 Port btn, input, 1: raw, asynchronous roll push-button, active-high.
REQ-010 Port face, output, 3: displayed die value, 0 = blank, 1..6 = face; feeds the 7-segment decoder.
REQ-011 Port face_valid, output, 1: high while face holds a settled final result.
REQ-012 Port rolling, output, 1: high in ROLL and SETTLE.
REQ-013 Port done, output, 1: one-cycle pulse when a roll settles.

Function
REQ-014 btn SHALL pass through a 2-flop synchroniser before any use.
REQ-015 The debounced level SHALL take the synchronised value only after DB_LIMIT consecutive cycles that differ from the current debounced level; any mismatch-free cycle restarts the count.
REQ-016 A press SHALL be a one-cycle pulse on a 0->1 transition of the debounced level.
REQ-017 A sample register SHALL load rand_byte[2:0] on every cycle where rand_valid=1 and rand_byte[2:0] is in 1..6; values 0 and 7 SHALL be discarded; has_sample SHALL be set on the first load.
REQ-018 FSM states SHALL be IDLE, ROLL, SETTLE and SHOW; the reset state is IDLE.
REQ-019 In IDLE or SHOW, a press SHALL enter ROLL on the next cycle, clear the tick and roll counters, and clear face_valid.
REQ-020 In ROLL, an animation tick SHALL fire when the tick counter reaches TICK_DIV-1; the counter then wraps to 0.
REQ-021 On each tick, face SHALL load the sample register if has_sample=1 (otherwise it is unchanged), and the roll counter SHALL increment.
REQ-022 The tick on which the roll counter equals ROLL_TICKS-1 SHALL move the FSM to SETTLE.
REQ-023 In SETTLE, the first cycle with rand_valid=1 and rand_byte[2:0] in 1..6 SHALL load face with that value directly (not through the sample register), set face_valid, pulse done, and enter SHOW on the next cycle.
REQ-024 SETTLE SHALL wait indefinitely for an acceptable sample, with no timeout.
REQ-025 Presses in ROLL or SETTLE SHALL be ignored.
REQ-026 When a press and a settle occur in the same cycle in SETTLE, the settle SHALL win and the press is dropped.
REQ-027 In SHOW, face and face_valid SHALL hold until the next press.
REQ-028 ena=0 SHALL force the FSM to IDLE and clear both counters, done, rolling and face_valid, while face is retained; the synchroniser, debounce logic and sample register keep running.

Reset
REQ-029 rst_n=0 SHALL asynchronously set: FSM=IDLE, face=0, face_valid=0, rolling=0, done=0, all counters=0, debounced level=0, synchroniser flops=0, sample register=0, has_sample=0.
REQ-030 Reset asserted mid-roll SHALL abort the roll with no done pulse; after release, the block waits in IDLE for a fresh press.

Structure
REQ-031 A shared package SHALL hold the state enum type (IDLE, ROLL, SETTLE, SHOW) and the face constants FACE_BLANK=0, FACE_MIN=1 and FACE_MAX=6.
REQ-032 Synchroniser plus debounce plus edge detect SHALL be one sub-module, btn_debounce, reusable by the other board-input stages.

Verification
REQ-033 Bench parameters SHALL be DB_LIMIT=4, TICK_DIV=3 and ROLL_TICKS=2.
REQ-034 Debounce: btn high for 3 cycles then low -> no press and the FSM stays IDLE; btn held high for 10 cycles -> exactly one press, with rolling rising 2+4+1 cycles after btn rose.
REQ-035 Full roll: press, rand_valid every cycle with rand_byte[2:0] = 5 -> face=5 after the first tick, SETTLE after 6 ROLL cycles, then done pulses once, face=5, face_valid=1.
REQ-036 Rejection: in SETTLE, feed rand_byte[2:0] = 0, 7, 7, 3 -> face stays at its old value for 3 cycles, then face=3 with done on the fourth.
REQ-037 Ignored press and restart: a press during ROLL -> roll length unchanged; a press in SHOW -> face_valid drops next cycle and rolling rises.
REQ-038 Abort: rst_n pulsed low mid-ROLL -> face=0 and rolling=0 immediately, with no done pulse; ena low in SHOW -> face_valid=0 while face is held.

Source files
------------

// File: rtl/dice_roller_pkg.sv
// dice_roller_pkg: shared state type and face constants for the dice roller.
package dice_roller_pkg;
  typedef enum logic [1:0] {IDLE, ROLL, SETTLE, SHOW} state_t;
  localparam logic [2:0] FACE_BLANK = 3'd0;
  localparam logic [2:0] FACE_MIN = 3'd1;
  localparam logic [2:0] FACE_MAX = 3'd6;
  function automatic logic is_face(input logic [2:0] v);
    return v >= FACE_MIN && v <= FACE_MAX;
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, counting debouncer and rising-edge press pulse.
module btn_debounce #(
  parameter logic [15:0] DB_LIMIT = 16'd50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);
  logic s0, s1, prev;
  logic [15:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      prev <= 1'b0;
      level <= 1'b0;
      cnt <= 16'd0;
    end else begin
      s0 <= btn;
      s1 <= s0;
      prev <= level;
      // the count only survives while every cycle disagrees with the accepted level
      if (s1 == level) cnt <= 16'd0;
      else if (cnt == DB_LIMIT - 16'd1) begin
        level <= s1;
        cnt <= 16'd0;
      end else cnt <= cnt + 16'd1;
    end
  assign press = level & ~prev;
endmodule

// File: rtl/dice_roller.sv
// dice_roller: debounced roll button drives an animated roll that settles on a random face 1..6.
module dice_roller import dice_roller_pkg::*; #(
  parameter logic [15:0] DB_LIMIT = 16'd50_000,
  parameter logic [23:0] TICK_DIV = 24'd2_500_000,
  parameter logic [7:0] ROLL_TICKS = 8'd20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] rand_byte,
  input  logic       rand_valid,
  input  logic       btn,
  output logic [2:0] face,
  output logic       face_valid,
  output logic       rolling,
  output logic       done
);
  state_t state, state_next;
  logic [23:0] tick_cnt;
  logic [7:0] roll_cnt;
  logic [2:0] sample;
  logic has_sample, press, btn_level, tick, last, acc, start, unused;
  btn_debounce #(.DB_LIMIT(DB_LIMIT)) u_db (
    .clk(clk),
    .rst_n(rst_n),
    .btn(btn),
    .level(btn_level),
    .press(press)
  );
  assign unused = ^{rand_byte[7:3], btn_level};
  assign acc = rand_valid && is_face(rand_byte[2:0]);
  assign tick = tick_cnt == TICK_DIV - 24'd1;
  assign last = roll_cnt == ROLL_TICKS - 8'd1;
  assign start = (state == IDLE || state == SHOW) && press;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE, SHOW: state_next = press ? ROLL : state;
      ROLL: state_next = (tick && last) ? SETTLE : ROLL;
      SETTLE: state_next = acc ? SHOW : SETTLE;
      default: state_next = IDLE;
    endcase
    if (!ena) state_next = IDLE;
  end
  always_comb rolling = ena && (state == ROLL || state == SETTLE);
  // the sample register keeps tracking the random source even while disabled
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sample <= FACE_BLANK;
      has_sample <= 1'b0;
    end else if (acc) begin
      sample <= rand_byte[2:0];
      has_sample <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      face <= FACE_BLANK;
      face_valid <= 1'b0;
      done <= 1'b0;
      tick_cnt <= 24'd0;
      roll_cnt <= 8'd0;
    end else if (!ena) begin
      face_valid <= 1'b0;
      done <= 1'b0;
      tick_cnt <= 24'd0;
      roll_cnt <= 8'd0;
    end else begin
      done <= 1'b0;
      if (start) begin
        tick_cnt <= 24'd0;
        roll_cnt <= 8'd0;
        face_valid <= 1'b0;
      end else if (state == ROLL) begin
        tick_cnt <= tick ? 24'd0 : tick_cnt + 24'd1;
        if (tick) begin
          roll_cnt <= roll_cnt + 8'd1;
          if (has_sample) face <= sample;
        end
      end else if (state == SETTLE && acc) begin
        face <= rand_byte[2:0];
        face_valid <= 1'b1;
        done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_dice_roller.sv
// tb_dice_roller: self-checking bench for dice_roller with short debounce/tick/roll parameters.
module tb_dice_roller;
  typedef struct packed {
    logic rv;
    logic [7:0] rb;
    logic [2:0] face;
    logic done;
    logic fv;
    logic rolling;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, rand_valid = 1'b0, btn = 1'b0;
  logic [7:0] rand_byte = 8'd0;
  logic [2:0] face;
  logic face_valid, rolling, done;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  vec_t tbl[4];
  vec_t sb[$];
  dice_roller #(.DB_LIMIT(16'd4), .TICK_DIV(24'd3), .ROLL_TICKS(8'd2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .rand_byte(rand_byte),
    .rand_valid(rand_valid),
    .btn(btn),
    .face(face),
    .face_valid(face_valid),
    .rolling(rolling),
    .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic find_roll(output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rolling) begin
        lat = k;
        break;
      end
    end
  endtask
  initial begin
    int lat, seen, snap, dn, dl, fface, ffv, pfv;
    vec_t e;
    tbl[0] = '{rv: 1'b1, rb: 8'h08, face: 3'd5, done: 1'b0, fv: 1'b0, rolling: 1'b1};
    tbl[1] = '{rv: 1'b1, rb: 8'h07, face: 3'd5, done: 1'b0, fv: 1'b0, rolling: 1'b1};
    tbl[2] = '{rv: 1'b1, rb: 8'hFF, face: 3'd5, done: 1'b0, fv: 1'b0, rolling: 1'b1};
    tbl[3] = '{rv: 1'b1, rb: 8'hA3, face: 3'd3, done: 1'b1, fv: 1'b1, rolling: 1'b0};
    wait_n(3);
    chk("rst_face", face, 0);
    chk("rst_fv", face_valid, 0);
    chk("rst_rolling", rolling, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    wait_n(2);
    btn = 1'b1;
    wait_n(3);
    btn = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rolling) seen = 1;
    end
    chk("glitch_no_roll", seen, 0);
    rand_valid = 1'b1;
    rand_byte = 8'hF5;
    wait_n(2);
    snap = done_cnt;
    btn = 1'b1;
    find_roll(lat);
    chk("press_latency", lat, 7);
    rand_valid = 1'b0;
    wait_n(2);
    chk("face_before_tick", face, 0);
    wait_n(1);
    chk("face_first_tick", face, 5);
    btn = 1'b0;
    wait_n(10);
    chk("settle_wait_rolling", rolling, 1);
    btn = 1'b1;
    wait_n(10);
    btn = 1'b0;
    chk("settle_press_ignored", rolling, 1);
    wait_n(10);
    chk("settle_no_done", done_cnt - snap, 0);
    chk("settle_face_held", face, 5);
    for (int i = 0; i < 4; i++) begin
      rand_valid = tbl[i].rv;
      rand_byte = tbl[i].rb;
      sb.push_back(tbl[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk($sformatf("rej%0d_face", i), face, e.face);
      chk($sformatf("rej%0d_done", i), done, e.done);
      chk($sformatf("rej%0d_fv", i), face_valid, e.fv);
      chk($sformatf("rej%0d_rolling", i), rolling, e.rolling);
    end
    rand_valid = 1'b0;
    wait_n(1);
    chk("show_done_low", done, 0);
    wait_n(4);
    chk("show_face_hold", face, 3);
    chk("show_fv_hold", face_valid, 1);
    rand_valid = 1'b1;
    rand_byte = 8'h2D;
    btn = 1'b1;
    lat = 0;
    pfv = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rolling) begin
        lat = k;
        break;
      end
      pfv = face_valid;
    end
    chk("restart_latency", lat, 7);
    chk("restart_fv_before", pfv, 1);
    chk("restart_fv_drop", face_valid, 0);
    dn = 0;
    dl = 0;
    fface = 0;
    ffv = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 3) btn = 1'b0;
      if (done) begin
        dn++;
        if (dl == 0) begin
          dl = k;
          fface = face;
          ffv = face_valid;
        end
      end
    end
    chk("roll_done_count", dn, 1);
    chk("roll_done_latency", dl, 7);
    chk("roll_done_face", fface, 5);
    chk("roll_done_fv", ffv, 1);
    ena = 1'b0;
    wait_n(1);
    chk("ena_fv", face_valid, 0);
    chk("ena_face", face, 5);
    chk("ena_rolling", rolling, 0);
    ena = 1'b1;
    wait_n(8);
    btn = 1'b1;
    find_roll(lat);
    chk("abort_latency", lat, 7);
    wait_n(2);
    snap = done_cnt;
    rst_n = 1'b0;
    btn = 1'b0;
    #1;
    chk("abort_face", face, 0);
    chk("abort_rolling", rolling, 0);
    wait_n(2);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (rolling) seen = 1;
    end
    chk("abort_stays_idle", seen, 0);
    chk("abort_no_done", done_cnt - snap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
